// File: rtl/ifu_fetch_queue.sv
// Multi-lane instruction fetch queue: compacts and truncates fetch packets,
// buffers them in a circular store and presents in-order slots to decode.
module ifu_fetch_queue #(
    parameter int FETCH_WIDTH = 4,
    parameter int DEQ_WIDTH   = 2,
    parameter int DEPTH       = 16,
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               redirect_valid,
    output logic                               cur_epoch,
    input  logic                               enq_valid,
    output logic                               enq_ready,
    input  logic                               enq_epoch,
    input  logic [PC_WIDTH-1:0]                enq_pc,
    input  logic [FETCH_WIDTH*INSTR_WIDTH-1:0] enq_instr,
    input  logic [FETCH_WIDTH-1:0]             enq_lane_valid,
    input  logic [FETCH_WIDTH-1:0]             enq_predicttaken,
    input  logic [FETCH_WIDTH*PC_WIDTH-1:0]    enq_predicttarget,
    output logic [DEQ_WIDTH-1:0]               deq_valid,
    input  logic                               deq_ready,
    output logic [DEQ_WIDTH*INSTR_WIDTH-1:0]   deq_instr,
    output logic [DEQ_WIDTH*PC_WIDTH-1:0]      deq_pc,
    output logic [DEQ_WIDTH-1:0]               deq_predicttaken,
    output logic [DEQ_WIDTH*PC_WIDTH-1:0]      deq_predicttarget,
    output logic [$clog2(DEPTH):0]             count,
    output logic                               fifo_empty,
    output logic                               fifo_full
);

    localparam int LW = $clog2(FETCH_WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INSTR_WIDTH-1:0] mem_instr  [DEPTH];
    logic [PC_WIDTH-1:0]    mem_pc     [DEPTH];
    logic                   mem_taken  [DEPTH];
    logic [PC_WIDTH-1:0]    mem_target [DEPTH];

    logic [AW-1:0]          head;
    logic [AW-1:0]          tail;
    logic                   epoch;

    logic [FETCH_WIDTH-1:0] keep;
    logic [LW:0]            offset [FETCH_WIDTH];
    logic [LW:0]            written;
    logic                   taken_seen;
    logic [PC_WIDTH-1:0]    lane_pc [FETCH_WIDTH];

    logic                   enq_fire;
    logic                   deq_fire;
    logic [CW-1:0]          wr_cnt;
    logic [CW-1:0]          popped;

    logic                   unused_pc;

    assign unused_pc = ^enq_pc[LW+1:0];
    assign cur_epoch = epoch;

    // Keep lanes up to and including the first predicted-taken one;
    // offset[i] is the prefix count of kept lanes below lane i.
    always_comb begin
        taken_seen = 1'b0;
        written    = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            keep[i]    = enq_lane_valid[i] && !taken_seen;
            offset[i]  = written;
            written    = written + {{LW{1'b0}}, keep[i]};
            taken_seen = taken_seen | (enq_lane_valid[i] & enq_predicttaken[i]);
            lane_pc[i] = {enq_pc[PC_WIDTH-1:LW+2], LW'(i), 2'b00};
        end
    end

    assign enq_ready = count <= CW'(DEPTH - FETCH_WIDTH);

    assign enq_fire = enq_valid && enq_ready && !redirect_valid
                      && !reset && (enq_epoch == epoch);
    assign deq_fire = deq_ready && deq_valid[0] && !redirect_valid;

    assign wr_cnt = enq_fire ? CW'(written) : '0;
    assign popped = !deq_fire ? '0
                  : (count < CW'(DEQ_WIDTH)) ? count : CW'(DEQ_WIDTH);

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            epoch <= 1'b0;
        end else if (redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            epoch <= ~epoch;
        end else begin
            tail  <= tail + AW'(wr_cnt);
            head  <= head + AW'(popped);
            count <= count + wr_cnt - popped;
        end
    end

    always_ff @(posedge clock) begin
        if (enq_fire) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (keep[i]) begin
                    mem_instr[tail + AW'(offset[i])] <=
                        enq_instr[i*INSTR_WIDTH +: INSTR_WIDTH];
                    mem_pc[tail + AW'(offset[i])]     <= lane_pc[i];
                    mem_taken[tail + AW'(offset[i])]  <= enq_predicttaken[i];
                    mem_target[tail + AW'(offset[i])] <=
                        enq_predicttarget[i*PC_WIDTH +: PC_WIDTH];
                end
            end
        end
    end

    for (genvar k = 0; k < DEQ_WIDTH; k++) begin : g_slot
        logic [AW-1:0] rd_idx;
        assign rd_idx       = head + AW'(k);
        assign deq_valid[k] = count > CW'(k);
        assign deq_instr[k*INSTR_WIDTH +: INSTR_WIDTH]  = mem_instr[rd_idx];
        assign deq_pc[k*PC_WIDTH +: PC_WIDTH]           = mem_pc[rd_idx];
        assign deq_predicttaken[k]                      = mem_taken[rd_idx];
        assign deq_predicttarget[k*PC_WIDTH +: PC_WIDTH] = mem_target[rd_idx];
    end

    assign fifo_empty = count == '0;
    assign fifo_full  = count == CW'(DEPTH);

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Scoreboard bench for ifu_fetch_queue: directed packets push expected
// entries, a negedge monitor pops and compares every presented slot.
module tb_ifu_fetch_queue;

    localparam int FW = 4;
    localparam int DW = 2;
    localparam int D  = 16;
    localparam int PW = 64;
    localparam int IW = 32;

    typedef struct {
        logic [PW-1:0] pc;
        logic [IW-1:0] instr;
        logic          taken;
        logic [PW-1:0] tgt;
    } ent_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              redirect_valid;
    logic              cur_epoch;
    logic              enq_valid;
    logic              enq_ready;
    logic              enq_epoch;
    logic [PW-1:0]     enq_pc;
    logic [FW*IW-1:0]  enq_instr;
    logic [FW-1:0]     enq_lane_valid;
    logic [FW-1:0]     enq_predicttaken;
    logic [FW*PW-1:0]  enq_predicttarget;
    logic [DW-1:0]     deq_valid;
    logic              deq_ready;
    logic [DW*IW-1:0]  deq_instr;
    logic [DW*PW-1:0]  deq_pc;
    logic [DW-1:0]     deq_predicttaken;
    logic [DW*PW-1:0]  deq_predicttarget;
    logic [4:0]        count;
    logic              fifo_empty;
    logic              fifo_full;

    ent_t exp_q[$];
    logic exp_epoch;
    int   checks = 0;
    int   errors = 0;

    ifu_fetch_queue #(
        .FETCH_WIDTH(FW), .DEQ_WIDTH(DW), .DEPTH(D),
        .PC_WIDTH(PW), .INSTR_WIDTH(IW)
    ) dut (
        .clock(clock), .reset(reset), .redirect_valid(redirect_valid),
        .cur_epoch(cur_epoch), .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_epoch(enq_epoch), .enq_pc(enq_pc), .enq_instr(enq_instr),
        .enq_lane_valid(enq_lane_valid), .enq_predicttaken(enq_predicttaken),
        .enq_predicttarget(enq_predicttarget), .deq_valid(deq_valid),
        .deq_ready(deq_ready), .deq_instr(deq_instr), .deq_pc(deq_pc),
        .deq_predicttaken(deq_predicttaken),
        .deq_predicttarget(deq_predicttarget), .count(count),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every slot shown while decode consumes must match the queue head.
    always @(negedge clock) begin
        if (!reset && !redirect_valid && deq_ready && deq_valid[0]) begin
            for (int k = 0; k < DW; k++) begin
                if (deq_valid[k]) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", 64'(exp_q.size()), 64'd1);
                    end else begin
                        ent_t e;
                        e = exp_q.pop_front();
                        chk("sb_pc", deq_pc[k*PW +: PW], e.pc);
                        chk("sb_instr", 64'(deq_instr[k*IW +: IW]), 64'(e.instr));
                        chk("sb_taken", 64'(deq_predicttaken[k]), 64'(e.taken));
                        chk("sb_target", deq_predicttarget[k*PW +: PW], e.tgt);
                    end
                end
            end
        end
    end

    task automatic enq_pkt(input logic [63:0] pc, input logic [3:0] lv,
                           input logic [3:0] tk, input logic ep,
                           input logic [31:0] ibase);
        int   first;
        ent_t e;
        logic [63:0] blk;
        blk   = {pc[63:4], 4'h0};
        first = FW;
        for (int i = 0; i < FW; i++) begin
            enq_instr[i*IW +: IW]         = ibase + 32'(i);
            enq_predicttarget[i*PW +: PW] = pc + 64'h100 * 64'(i + 1);
            if (lv[i] && tk[i] && first == FW) first = i;
        end
        enq_pc           = pc;
        enq_lane_valid   = lv;
        enq_predicttaken = tk;
        enq_epoch        = ep;
        enq_valid        = 1'b1;
        if (enq_ready && ep == exp_epoch && !redirect_valid && !reset) begin
            for (int i = 0; i < FW; i++) begin
                if (lv[i] && i <= first) begin
                    e.pc    = blk + 64'(4 * i);
                    e.instr = ibase + 32'(i);
                    e.taken = tk[i];
                    e.tgt   = pc + 64'h100 * 64'(i + 1);
                    exp_q.push_back(e);
                end
            end
        end
        step();
        enq_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        deq_ready = 1'b1;
        repeat (n) step();
        deq_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        enq_valid = 1'b0;
        enq_epoch = 1'b0;
        enq_pc = '0;
        enq_instr = '0;
        enq_lane_valid = '0;
        enq_predicttaken = '0;
        enq_predicttarget = '0;
        deq_ready = 1'b0;
        exp_epoch = 1'b0;
        repeat (2) step();
        reset = 1'b0;

        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        chk("rst_full", 64'(fifo_full), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_epoch", 64'(cur_epoch), 64'd0);

        // Full packet, then drain in two cycles
        enq_pkt(64'h1000, 4'b1111, 4'b0000, 1'b0, 32'hA0);
        chk("t1_count", 64'(count), 64'd4);
        chk("t1_deq_valid", 64'(deq_valid), 64'd3);
        chk("t1_pc0", deq_pc[63:0], 64'h1000);
        chk("t1_pc1", deq_pc[127:64], 64'h1004);
        drain(2);
        chk("t1_empty", 64'(fifo_empty), 64'd1);
        chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

        // Truncation after predicted-taken lane 2
        enq_pkt(64'h1000, 4'b1110, 4'b0100, 1'b0, 32'hB0);
        chk("t2_count", 64'(count), 64'd2);
        chk("t2_pc0", deq_pc[63:0], 64'h1004);
        chk("t2_pc1", deq_pc[127:64], 64'h1008);
        chk("t2_taken", 64'(deq_predicttaken), 64'b10);
        chk("t2_target1", deq_predicttarget[127:64], 64'h1300);
        drain(1);
        chk("t2_empty", 64'(fifo_empty), 64'd1);

        // Fill to DEPTH, then watch enq_ready recover
        for (int p = 0; p < 4; p++)
            enq_pkt(64'h2000 + 64'(p * 16), 4'b1111, 4'b0000, 1'b0,
                    32'hD000 + 32'(p * 16));
        chk("t3_count16", 64'(count), 64'd16);
        chk("t3_full", 64'(fifo_full), 64'd1);
        chk("t3_ready_full", 64'(enq_ready), 64'd0);
        drain(1);
        chk("t3_count14", 64'(count), 64'd14);
        chk("t3_ready14", 64'(enq_ready), 64'd0);
        drain(1);
        chk("t3_count12", 64'(count), 64'd12);
        chk("t3_ready12", 64'(enq_ready), 64'd1);
        drain(6);
        chk("t3_empty", 64'(fifo_empty), 64'd1);

        // Wrap: three-lane packets alternating with dequeues
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                if (enq_ready)
                    enq_pkt(64'h3000 + 64'(i * 16),
                            (i % 4 == 0) ? 4'b0111 : 4'b1111,
                            (i % 4 == 0) ? 4'b0000 : 4'b0100,
                            exp_epoch, 32'hC000_0000 + 32'(i * 16));
                else
                    step();
            end else begin
                drain(1);
            end
        end
        drain(12);
        chk("t4_empty", 64'(fifo_empty), 64'd1);
        chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);

        // Redirect with a simultaneous packet, then stale and fresh packets
        enq_pkt(64'h4000, 4'b1111, 4'b0000, 1'b0, 32'hE0);
        enq_pkt(64'h4010, 4'b0011, 4'b0000, 1'b0, 32'hE8);
        chk("t5_count6", 64'(count), 64'd6);
        chk("t5_epoch0", 64'(cur_epoch), 64'd0);
        redirect_valid = 1'b1;
        enq_pkt(64'h4020, 4'b1111, 4'b0000, 1'b0, 32'hF0);
        redirect_valid = 1'b0;
        exp_q.delete();
        exp_epoch = 1'b1;
        chk("t5_count0", 64'(count), 64'd0);
        chk("t5_epoch1", 64'(cur_epoch), 64'd1);
        chk("t5_deq_valid", 64'(deq_valid), 64'd0);
        chk("t5_ready", 64'(enq_ready), 64'd1);
        enq_pkt(64'h5000, 4'b1111, 4'b0000, 1'b0, 32'h50);
        chk("t5_stale_drop", 64'(count), 64'd0);
        enq_pkt(64'h6000, 4'b1111, 4'b0000, 1'b1, 32'h60);
        chk("t5_fresh", 64'(count), 64'd4);
        chk("t5_fresh_pc", deq_pc[63:0], 64'h6000);
        drain(2);
        chk("t5_empty", 64'(fifo_empty), 64'd1);

        // Simultaneous enqueue and dequeue, then reset beats redirect
        enq_pkt(64'h7000, 4'b1111, 4'b0000, 1'b1, 32'h70);
        enq_pkt(64'h7010, 4'b1111, 4'b0000, 1'b1, 32'h78);
        chk("t6_count8", 64'(count), 64'd8);
        deq_ready = 1'b1;
        enq_pkt(64'h7020, 4'b1111, 4'b0000, 1'b1, 32'h80);
        deq_ready = 1'b0;
        chk("t6_count10", 64'(count), 64'd10);
        reset = 1'b1;
        redirect_valid = 1'b1;
        step();
        reset = 1'b0;
        redirect_valid = 1'b0;
        exp_q.delete();
        exp_epoch = 1'b0;
        chk("t6_rst_count", 64'(count), 64'd0);
        chk("t6_rst_epoch", 64'(cur_epoch), 64'd0);
        chk("t6_rst_ready", 64'(enq_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
Parametrised successor to the single-lane instruction buffer. Accepts a FETCH_WIDTH-lane fetch packet per handshake, with per-lane valid and BPU prediction. It compacts valid lanes, truncates after the first predicted-taken lane, and stores them in a DEPTH-entry circular queue. It presents up to DEQ_WIDTH in-order instructions per cycle to decode, and uses an epoch bit to drop in-flight fetch responses that are stale after a redirect.

Parameters:
FETCH_WIDTH, 4, lanes per fetch packet (power of 2, ≥2)
DEQ_WIDTH, 2, instructions presented to decode per cycle (1..FETCH_WIDTH)
DEPTH, 16, queue entries (power of 2, ≥ 2*FETCH_WIDTH)
PC_WIDTH, 64, PC width
INSTR_WIDTH, 32, instruction width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  backend redirect/flush
cur_epoch  out  1  current fetch epoch; fetch side tags requests with it
enq_valid  in  1  fetch packet valid
enq_ready  out  1  queue can take a full packet
enq_epoch  in  1  epoch tag of the packet
enq_pc  in  PC_WIDTH  packet PC; block-aligned base used for lane PCs
enq_instr  in  FETCH_WIDTH*INSTR_WIDTH  lane i at [i*INSTR_WIDTH +: INSTR_WIDTH]
enq_lane_valid  in  FETCH_WIDTH  per-lane valid
enq_predicttaken  in  FETCH_WIDTH  per-lane predicted taken
enq_predicttarget  in  FETCH_WIDTH*PC_WIDTH  per-lane predicted target
deq_valid  out  DEQ_WIDTH  thermometer; bit k = slot k holds an instruction
deq_ready  in  1  decode consumes all valid slots this cycle
deq_instr  out  DEQ_WIDTH*INSTR_WIDTH  slot instructions
deq_pc  out  DEQ_WIDTH*PC_WIDTH  slot PCs
deq_predicttaken  out  DEQ_WIDTH  slot prediction
deq_predicttarget  out  DEQ_WIDTH*PC_WIDTH  slot targets
count  out  $clog2(DEPTH)+1  occupancy
fifo_empty  out  1  count==0
fifo_full  out  1  count==DEPTH

Behaviour:
- Single clock domain. Synchronous, active-high reset: head=tail=0, count=0, cur_epoch=0. Outputs after reset: deq_valid=0, fifo_empty=1, fifo_full=0, enq_ready=1.
- enq_ready = (DEPTH-count) ≥ FETCH_WIDTH. It is computed from registered count only and has no dependency on enq_* inputs.
- Enqueue fires when enq_valid && enq_ready && !redirect_valid && enq_epoch==cur_epoch.
- A stale packet (enq_epoch≠cur_epoch) completes its handshake when enq_ready=1 and is discarded with no state change.
- Lane keep mask: lane i is kept if enq_lane_valid[i] is set and no lower lane j<i has enq_lane_valid[j]&&enq_predicttaken[j].
- Kept lanes are written in ascending lane order to consecutive entries starting at tail. Tail advances by popcount(keep) and wraps mod DEPTH. A packet with keep=0 is accepted with no write.
- Lane PC = {enq_pc[PC_WIDTH-1:log2(FETCH_WIDTH)+2], i[log2(FETCH_WIDTH)-1:0], 2'b00}. Each entry stores instr, pc, predicttaken, predicttarget.
- deq_valid[k] = (count > k). Slot k reads entry (head+k) mod DEPTH combinationally from storage. Data on slots with deq_valid[k]=0 is don't-care.
- Dequeue fires when deq_ready && deq_valid[0]. Head advances by min(count, DEQ_WIDTH).
- Same-cycle enqueue and dequeue: count_next = count + written - popped. enq_ready uses pre-pop count, which is conservative by design.
- Redirect has priority over everything. When redirect_valid=1 in cycle t:
  - head=tail=0, count=0, cur_epoch toggles;
  - that cycle's enqueue and dequeue are ignored;
  - deq_valid=0 and enq_ready=1 from cycle t+1.
- Latency: an enqueue accepted in cycle t is visible on deq_valid in cycle t+1.
- No overflow is possible by construction. A dequeue with count=0 is a no-op.
- reset asserted mid-operation overrides redirect and returns all state to reset values in the next cycle.
- Area: storage is DEPTH registers of INSTR_WIDTH+2*PC_WIDTH+1 bits, with no SRAM. Write uses a prefix-sum of keep to derive each lane's entry offset.

Test Plan:
1. Reset, then enq pc=0x1000, lane_valid=4'b1111, no taken, instr 0xA0..0xA3. Expected: next cycle count=4, deq_valid=2'b11, deq_pc=0x1000/0x1004. With deq_ready=1 for two cycles, the four instructions drain in order and fifo_empty=1.
2. Predicted-taken truncation: lane_valid=4'b1110, predicttaken=4'b0100. Expected: only lanes 1,2 stored (pc 0x1004,0x1008), count=2, deq_predicttaken=2'b10 and slot 1 target matches lane 2.
3. Fill: enq full packets with deq_ready=0. Expected: after 4 packets count=16, fifo_full=1, enq_ready=0. One dequeue makes count=14 and enq_ready stays 0. A second dequeue makes count=12 and enq_ready=1.
4. Wrap: alternate enq of 3 kept lanes with deq of 2 over 40 cycles. Expected: every dequeued PC matches a scoreboard in order, including across index 15→0.
5. Redirect with in-flight packet: count=6 and cur_epoch=0 when redirect_valid pulses, with simultaneous enq. Expected: next cycle count=0 and cur_epoch=1. A subsequent packet with enq_epoch=0 is handshaken and dropped (count stays 0). A packet with enq_epoch=1 is stored.
6. Simultaneous enq of 4 and deq of 2 at count=8. Expected: count=10. Reset asserted together with redirect_valid: next cycle count=0 and cur_epoch=0.
